// File: rtl/or32_selftest.sv
// Built-in self-test engine for the ALU32 bitwise OR unit: drives operands, checks In1 | In2
// against the unit's result and reports error count, first failing index and pass/fail.
module or32_selftest #(
    parameter logic [31:0] SEED    = 32'h1234_5678,
    parameter int unsigned COUNT_W = 16,
    parameter int unsigned DUT_LAT = 0
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [COUNT_W-1:0] NumVectors,
    output logic [31:0]        In1,
    output logic [31:0]        In2,
    input  logic [31:0]        DutOut,
    output logic               Busy,
    output logic               Done,
    output logic               Pass,
    output logic [COUNT_W-1:0] ErrCount,
    output logic [COUNT_W-1:0] FirstFailIdx
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [31:0]        LfsrMask = 32'h8020_0003;
    localparam logic [2:0]         Lat      = 3'(DUT_LAT);
    localparam logic [COUNT_W-1:0] AllOnes  = '1;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LfsrMask) : (s >> 1);
    endfunction

    logic [1:0]         state_q, state_d;
    logic [31:0]        in1_q, in1_d;
    logic [31:0]        in2_q, in2_d;
    logic [31:0]        exp_q, exp_d;
    logic [31:0]        lfsr1_q, lfsr1_d;
    logic [31:0]        lfsr2_q, lfsr2_d;
    logic [COUNT_W-1:0] idx_q, idx_d;
    logic [COUNT_W-1:0] num_q, num_d;
    logic [COUNT_W-1:0] err_q, err_d;
    logic [COUNT_W-1:0] ffi_q, ffi_d;
    logic [2:0]         wait_q, wait_d;

    logic [COUNT_W-1:0] nxt_idx;
    logic [31:0]        vec_a, vec_b;
    logic               vec_rand;

    // Operands for the vector following the current one; indices >= 4 come from the LFSRs.
    always_comb begin
        nxt_idx  = idx_q + COUNT_W'(1);
        vec_a    = lfsr1_q;
        vec_b    = lfsr2_q;
        vec_rand = 1'b0;
        if (nxt_idx == COUNT_W'(1)) begin
            vec_a = 32'hFFFF_FFFF;
            vec_b = 32'h0000_0000;
        end else if (nxt_idx == COUNT_W'(2)) begin
            vec_a = 32'hAAAA_AAAA;
            vec_b = 32'h5555_5555;
        end else if (nxt_idx == COUNT_W'(3)) begin
            vec_a = 32'hFFFF_FFFF;
            vec_b = 32'hFFFF_FFFF;
        end else begin
            vec_rand = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        exp_d   = exp_q;
        lfsr1_d = lfsr1_q;
        lfsr2_d = lfsr2_q;
        idx_d   = idx_q;
        num_d   = num_q;
        err_d   = err_q;
        ffi_d   = ffi_q;
        wait_d  = wait_q;
        case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    err_d   = '0;
                    ffi_d   = AllOnes;
                    lfsr1_d = SEED;
                    lfsr2_d = ~SEED;
                    if (NumVectors == '0) begin
                        state_d = StDone;
                    end else begin
                        num_d   = NumVectors;
                        idx_d   = '0;
                        in1_d   = 32'h0;
                        in2_d   = 32'h0;
                        exp_d   = 32'h0;
                        wait_d  = Lat;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (wait_q != 3'd0) begin
                    wait_d = wait_q - 3'd1;
                end else begin
                    if (DutOut != exp_q) begin
                        if (err_q != AllOnes) err_d = err_q + COUNT_W'(1);
                        if (err_q == '0) ffi_d = idx_q;
                    end
                    if (idx_q == num_q - COUNT_W'(1)) begin
                        state_d = StDone;
                        in1_d   = 32'h0;
                        in2_d   = 32'h0;
                        exp_d   = 32'h0;
                    end else begin
                        idx_d  = nxt_idx;
                        in1_d  = vec_a;
                        in2_d  = vec_b;
                        exp_d  = vec_a | vec_b;
                        wait_d = Lat;
                        if (vec_rand) begin
                            lfsr1_d = lfsr_step(lfsr1_q);
                            lfsr2_d = lfsr_step(lfsr2_q);
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            in1_q   <= 32'h0;
            in2_q   <= 32'h0;
            exp_q   <= 32'h0;
            lfsr1_q <= SEED;
            lfsr2_q <= ~SEED;
            idx_q   <= '0;
            num_q   <= '0;
            err_q   <= '0;
            ffi_q   <= AllOnes;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            exp_q   <= exp_d;
            lfsr1_q <= lfsr1_d;
            lfsr2_q <= lfsr2_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            err_q   <= err_d;
            ffi_q   <= ffi_d;
            wait_q  <= wait_d;
        end
    end

    assign In1          = in1_q;
    assign In2          = in2_q;
    assign Busy         = (state_q == StRun);
    assign Done         = (state_q == StDone);
    assign Pass         = Done && (err_q == '0);
    assign ErrCount     = err_q;
    assign FirstFailIdx = ffi_q;

endmodule
